// File: rtl/fas_freq_detect.sv
`default_nettype none
// ============================================================================
// Module      : fas_freq_detect
// Description : Spectrum peak picker. Captures sixteen packed complex FFT
//               words on fft_valid, scans the captured bins one per clock
//               computing exact squared magnitude, and reports the index of
//               the strongest bin on freq with a one-cycle done strobe.
//               Ties keep the lower index.
// Ports       : clk        - rising-edge clock
//               rst        - asynchronous active-low reset
//               fft_valid  - input word set valid this cycle
//               fft_d0..15 - bin k = {real[2*DW-1:DW], imag[DW-1:0]}, signed
//               busy       - capture/scan in progress, fft_valid ignored
//               done       - one-cycle strobe, freq holds a new result
//               freq       - index of the max-magnitude bin
// Options     : FAS_FD_HALF_SPECTRUM_EN - scan only bins 0..8
// Revision    : 1.0 - initial release
// ============================================================================
module fas_freq_detect #(
    parameter int DW = 16,
    parameter int MW = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            fft_valid,
    input  logic [2*DW-1:0] fft_d0,
    input  logic [2*DW-1:0] fft_d1,
    input  logic [2*DW-1:0] fft_d2,
    input  logic [2*DW-1:0] fft_d3,
    input  logic [2*DW-1:0] fft_d4,
    input  logic [2*DW-1:0] fft_d5,
    input  logic [2*DW-1:0] fft_d6,
    input  logic [2*DW-1:0] fft_d7,
    input  logic [2*DW-1:0] fft_d8,
    input  logic [2*DW-1:0] fft_d9,
    input  logic [2*DW-1:0] fft_d10,
    input  logic [2*DW-1:0] fft_d11,
    input  logic [2*DW-1:0] fft_d12,
    input  logic [2*DW-1:0] fft_d13,
    input  logic [2*DW-1:0] fft_d14,
    input  logic [2*DW-1:0] fft_d15,
    output logic            busy,
    output logic            done,
    output logic [3:0]      freq
);

`ifdef FAS_FD_HALF_SPECTRUM_EN
    localparam int c_NBINS = 9;
`else
    localparam int c_NBINS = 16;
`endif
    localparam logic [3:0] c_LAST = 4'(c_NBINS - 1);

    localparam logic [1:0] c_IDLE = 2'd0;
    localparam logic [1:0] c_SCAN = 2'd1;
    localparam logic [1:0] c_DONE = 2'd2;

    // ------------------------------------------------------------------
    // Input word gather (only the bins that will be scanned are stored)
    // ------------------------------------------------------------------
    logic [2*DW-1:0] w_din [0:c_NBINS-1];

    assign w_din[0] = fft_d0;
    assign w_din[1] = fft_d1;
    assign w_din[2] = fft_d2;
    assign w_din[3] = fft_d3;
    assign w_din[4] = fft_d4;
    assign w_din[5] = fft_d5;
    assign w_din[6] = fft_d6;
    assign w_din[7] = fft_d7;
    assign w_din[8] = fft_d8;
`ifdef FAS_FD_HALF_SPECTRUM_EN
    // Upper bins are redundant for real input and never stored.
    logic w_unused_hi;
    assign w_unused_hi = ^{fft_d9, fft_d10, fft_d11, fft_d12,
                           fft_d13, fft_d14, fft_d15};
`else
    assign w_din[9]  = fft_d9;
    assign w_din[10] = fft_d10;
    assign w_din[11] = fft_d11;
    assign w_din[12] = fft_d12;
    assign w_din[13] = fft_d13;
    assign w_din[14] = fft_d14;
    assign w_din[15] = fft_d15;
`endif

    // ------------------------------------------------------------------
    // State and datapath registers
    // ------------------------------------------------------------------
    logic [1:0]      r_state;
    logic [1:0]      w_state_nxt;
    logic            w_capture;
    logic            w_last;
    logic [3:0]      r_cnt;
    logic [MW-1:0]   r_max;
    logic [3:0]      r_idx;
    logic [3:0]      r_freq;
    logic [2*DW-1:0] r_buf [0:c_NBINS-1];

    // Capture buffer carries no reset; its contents are only read in SCAN,
    // which can only be entered through a capture.
    always_ff @(posedge clk) begin
        if (w_capture) begin
            for (int i = 0; i < c_NBINS; i++) begin
                r_buf[i] <= w_din[i];
            end
        end
    end

    // ------------------------------------------------------------------
    // Magnitude of the bin under evaluation. Both squares are
    // non-negative (max 2^(2*DW-2)), so the sum fits 2*DW unsigned bits
    // and must be treated as unsigned to keep {8000,8000} = 2^31 largest.
    // ------------------------------------------------------------------
    logic [2*DW-1:0]        w_word;
    logic signed [DW-1:0]   w_re;
    logic signed [DW-1:0]   w_im;
    logic signed [2*DW-1:0] w_re_sq;
    logic signed [2*DW-1:0] w_im_sq;
    logic [MW-1:0]          w_mag;
    logic                   w_take;

    assign w_word  = r_buf[r_cnt];
    assign w_re    = w_word[2*DW-1:DW];
    assign w_im    = w_word[DW-1:0];
    assign w_re_sq = w_re * w_re;
    assign w_im_sq = w_im * w_im;
    assign w_mag   = MW'($unsigned(w_re_sq)) + MW'($unsigned(w_im_sq));

    // Bin 0 seeds the running max; later bins need strictly greater.
    assign w_take  = (r_cnt == 4'd0) || (w_mag > r_max);

    // ------------------------------------------------------------------
    // Next-state logic. DONE accepts a new capture exactly like IDLE.
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        w_capture   = 1'b0;
        w_last      = 1'b0;
        case (r_state)
            c_IDLE, c_DONE: begin
                if (fft_valid) begin
                    w_capture   = 1'b1;
                    w_state_nxt = c_SCAN;
                end else begin
                    w_state_nxt = c_IDLE;
                end
            end
            c_SCAN: begin
                if (r_cnt == c_LAST) begin
                    w_last      = 1'b1;
                    w_state_nxt = c_DONE;
                end
            end
            default: w_state_nxt = c_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= c_IDLE;
            r_cnt   <= 4'd0;
            r_max   <= '0;
            r_idx   <= 4'd0;
            r_freq  <= 4'd0;
        end else begin
            r_state <= w_state_nxt;

            if (w_capture) begin
                r_cnt <= 4'd0;
            end else if ((r_state == c_SCAN) && !w_last) begin
                r_cnt <= r_cnt + 4'd1;
            end

            if ((r_state == c_SCAN) && w_take) begin
                r_max <= w_mag;
                r_idx <= r_cnt;
            end

            // The last bin's own comparison must be folded into the result
            // since r_idx only reflects it one edge later.
            if (w_last) begin
                r_freq <= w_take ? r_cnt : r_idx;
            end
        end
    end

    assign busy = (r_state == c_SCAN);
    assign done = (r_state == c_DONE);
    assign freq = r_freq;

endmodule
`default_nettype wire
